// File: rtl/fluxo_dados_asteroides_n_pkg.sv
// Shared definitions for the multi-asteroid datapath: scan FSM encoding and
// counter width helpers.
package fluxo_dados_asteroides_n_pkg;

    typedef enum logic [1:0] {
        OCIOSO = 2'd0,
        VARRE  = 2'd1,
        FIM    = 2'd2
    } estado_t;

    // Bits needed to count 0..n inclusive
    function automatic int largura_cont(input int n);
        return $clog2(n + 1);
    endfunction

    // Bits needed to index n slots, never zero
    function automatic int largura_idx(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fluxo_dados_asteroides_n_if.sv
// Command/status bundle between the game control unit (master) and the
// asteroid datapath (slave).
interface fluxo_dados_asteroides_n_if
    import fluxo_dados_asteroides_n_pkg::*;
#(
    parameter int N_AST    = 4,
    parameter int COOR_W   = 4,
    parameter int VIDAS_W  = 4,
    parameter int PONTOS_W = 8
);
    logic                              iniciar_passo;
    logic                              spawn_valid;
    logic [COOR_W-1:0]                 spawn_x, spawn_y;
    logic                              spawn_ready;
    logic                              tiro_valid;
    logic [COOR_W-1:0]                 tiro_x, tiro_y;
    logic                              recarregar_vidas;
    logic                              ocupado;
    logic                              passo_fim;
    logic                              colisao;
    logic                              acertou;
    logic                              vidas;
    logic [VIDAS_W-1:0]                num_vidas;
    logic [PONTOS_W-1:0]               pontos;
    logic [largura_cont(N_AST)-1:0]    num_ativos;
    logic [N_AST-1:0]                  db_ativos;
    logic [N_AST*COOR_W-1:0]           db_coor_x, db_coor_y;

    modport master (
        output iniciar_passo, spawn_valid, spawn_x, spawn_y, tiro_valid, tiro_x, tiro_y,
               recarregar_vidas,
        input  spawn_ready, ocupado, passo_fim, colisao, acertou, vidas, num_vidas, pontos,
               num_ativos, db_ativos, db_coor_x, db_coor_y
    );

    modport slave (
        input  iniciar_passo, spawn_valid, spawn_x, spawn_y, tiro_valid, tiro_x, tiro_y,
               recarregar_vidas,
        output spawn_ready, ocupado, passo_fim, colisao, acertou, vidas, num_vidas, pontos,
               num_ativos, db_ativos, db_coor_x, db_coor_y
    );

endinterface

// File: rtl/fluxo_dados_asteroides_n_slot_asteroide.sv
// One asteroid slot: active flag and position, stepping one unit per axis
// toward the ship; flags shot matches and ship collisions.
module fluxo_dados_asteroides_n_slot_asteroide #(
    parameter int COOR_W = 4,
    parameter int NAVE_X = 4,
    parameter int NAVE_Y = 0
) (
    input  logic              clock,
    input  logic              clear_n,
    input  logic              carrega,
    input  logic [COOR_W-1:0] carga_x,
    input  logic [COOR_W-1:0] carga_y,
    input  logic              passo,
    input  logic              limpa,
    input  logic [COOR_W-1:0] alvo_x,
    input  logic [COOR_W-1:0] alvo_y,
    output logic              ativo,
    output logic [COOR_W-1:0] x,
    output logic [COOR_W-1:0] y,
    output logic              acerto,
    output logic              colide
);
    localparam logic [COOR_W-1:0] NX = COOR_W'(NAVE_X);
    localparam logic [COOR_W-1:0] NY = COOR_W'(NAVE_Y);

    logic [COOR_W-1:0] prox_x, prox_y;

    // Target is in range, so a single-unit move toward it can never wrap
    function automatic logic [COOR_W-1:0] aproxima(input logic [COOR_W-1:0] c,
                                                   input logic [COOR_W-1:0] t);
        if (c < t)      return c + COOR_W'(1);
        else if (c > t) return c - COOR_W'(1);
        else            return c;
    endfunction

    assign prox_x = aproxima(x, NX);
    assign prox_y = aproxima(y, NY);
    assign colide = passo && ativo && (prox_x == NX) && (prox_y == NY);
    assign acerto = ativo && (x == alvo_x) && (y == alvo_y);

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            ativo <= 1'b0;
            x     <= '0;
            y     <= '0;
        end else if (carrega) begin
            ativo <= 1'b1;
            x     <= carga_x;
            y     <= carga_y;
        end else if (limpa) begin
            ativo <= 1'b0;
        end else if (passo && ativo) begin
            x     <= prox_x;
            y     <= prox_y;
            ativo <= !colide;
        end
    end

endmodule

// File: rtl/fluxo_dados_asteroides_n.sv
// Asteroid-field datapath: N_AST slots moved by a one-slot-per-cycle scan,
// spawn into the lowest free slot, shot hits, lives and score counters.
module fluxo_dados_asteroides_n
    import fluxo_dados_asteroides_n_pkg::*;
#(
    parameter int N_AST     = 4,
    parameter int COOR_W    = 4,
    parameter int VIDAS_W   = 4,
    parameter int VIDAS_INI = 3,
    parameter int PONTOS_W  = 8,
    parameter int NAVE_X    = 4,
    parameter int NAVE_Y    = 0
) (
    input  logic                     clock,
    input  logic                     clear_n,
    fluxo_dados_asteroides_n_if.slave bus
);
    localparam int CNT_W = largura_cont(N_AST);
    localparam int IDX_W = largura_idx(N_AST);

    estado_t                        estado, estado_prox;
    logic [IDX_W-1:0]               indice, indice_prox;
    logic [N_AST-1:0]               ativos, acertos, colide, carrega, varre, livre;
    logic [N_AST-1:0][COOR_W-1:0]   coor_x, coor_y;
    logic                           ocioso, tiro_ok, spawn_ok;
    logic [CNT_W-1:0]               n_acertos;
    logic [PONTOS_W:0]              soma_pontos;
    logic                           colisao_r, acertou_r;
    logic [VIDAS_W-1:0]             vidas_r;
    logic [PONTOS_W-1:0]            pontos_r;

    function automatic logic [CNT_W-1:0] popcount(input logic [N_AST-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < N_AST; i++) c = c + CNT_W'(v[i]);
        return c;
    endfunction

    assign ocioso   = (estado == OCIOSO);
    assign livre    = ~ativos;
    assign tiro_ok  = ocioso && bus.tiro_valid;
    assign spawn_ok = ocioso && bus.spawn_valid && (|livre);
    // Lowest set bit of the free mask, taken before this cycle's shot clears anything
    assign carrega  = spawn_ok ? (livre & (~livre + N_AST'(1))) : '0;

    for (genvar i = 0; i < N_AST; i++) begin : g_slot
        assign varre[i] = (estado == VARRE) && (indice == IDX_W'(i));

        fluxo_dados_asteroides_n_slot_asteroide #(
            .COOR_W(COOR_W), .NAVE_X(NAVE_X), .NAVE_Y(NAVE_Y)
        ) u_slot (
            .clock   (clock),
            .clear_n (clear_n),
            .carrega (carrega[i]),
            .carga_x (bus.spawn_x),
            .carga_y (bus.spawn_y),
            .passo   (varre[i]),
            .limpa   (tiro_ok && acertos[i]),
            .alvo_x  (bus.tiro_x),
            .alvo_y  (bus.tiro_y),
            .ativo   (ativos[i]),
            .x       (coor_x[i]),
            .y       (coor_y[i]),
            .acerto  (acertos[i]),
            .colide  (colide[i])
        );
    end

    always_comb begin
        estado_prox = estado;
        indice_prox = indice;
        case (estado)
            OCIOSO: if (bus.iniciar_passo) begin
                estado_prox = VARRE;
                indice_prox = '0;
            end
            VARRE: if (indice == IDX_W'(N_AST - 1)) estado_prox = FIM;
                   else indice_prox = indice + IDX_W'(1);
            FIM:     estado_prox = OCIOSO;
            default: estado_prox = OCIOSO;
        endcase
    end

    assign n_acertos   = tiro_ok ? popcount(acertos) : '0;
    assign soma_pontos = {1'b0, pontos_r} + (PONTOS_W + 1)'(n_acertos);

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            estado    <= OCIOSO;
            indice    <= '0;
            colisao_r <= 1'b0;
            acertou_r <= 1'b0;
            vidas_r   <= VIDAS_W'(VIDAS_INI);
            pontos_r  <= '0;
        end else begin
            estado    <= estado_prox;
            indice    <= indice_prox;
            colisao_r <= |colide;
            acertou_r <= (n_acertos != '0);
            if (bus.recarregar_vidas)
                vidas_r <= VIDAS_W'(VIDAS_INI);
            else if ((|colide) && (vidas_r != '0))
                vidas_r <= vidas_r - VIDAS_W'(1);
            pontos_r  <= soma_pontos[PONTOS_W] ? '1 : soma_pontos[PONTOS_W-1:0];
        end
    end

    assign bus.spawn_ready = ocioso && (|livre);
    assign bus.ocupado     = !ocioso;
    assign bus.passo_fim   = (estado == FIM);
    assign bus.colisao     = colisao_r;
    assign bus.acertou     = acertou_r;
    assign bus.num_vidas   = vidas_r;
    assign bus.vidas       = (vidas_r != '0);
    assign bus.pontos      = pontos_r;
    assign bus.num_ativos  = popcount(ativos);
    assign bus.db_ativos   = ativos;
    assign bus.db_coor_x   = coor_x;
    assign bus.db_coor_y   = coor_y;

endmodule

// File: tb/tb_fluxo_dados_asteroides_n.sv
// Scoreboard bench for fluxo_dados_asteroides_n: a slot-list reference model
// queues expected colisao/acertou/passo_fim events; a monitor checks them.
module tb_fluxo_dados_asteroides_n;
    localparam int N = 4, W = 4, VW = 4, PW = 8, VINI = 3, NX = 4, NY = 0;
    localparam int PMAX = (1 << PW) - 1;

    logic clock = 1'b0;
    logic clear_n = 1'b0;
    always #5 clock = ~clock;

    fluxo_dados_asteroides_n_if #(.N_AST(N), .COOR_W(W), .VIDAS_W(VW), .PONTOS_W(PW)) bus ();

    fluxo_dados_asteroides_n #(
        .N_AST(N), .COOR_W(W), .VIDAS_W(VW), .VIDAS_INI(VINI), .PONTOS_W(PW),
        .NAVE_X(NX), .NAVE_Y(NY)
    ) dut (.clock(clock), .clear_n(clear_n), .bus(bus));

    typedef struct {
        logic [N-1:0]   act;
        logic [N*W-1:0] x;
        logic [N*W-1:0] y;
        int             nat;
        int             lives;
        int             score;
    } snap_t;

    int    errors = 0;
    int    checks = 0;
    int    col_q[$];
    int    hit_q[$];
    snap_t fim_q[$];

    // Reference model: plain list of asteroids
    bit ma[N];
    int mx[N], my[N];
    int lives, score;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        bus.iniciar_passo = 0; bus.spawn_valid = 0; bus.spawn_x = '0; bus.spawn_y = '0;
        bus.tiro_valid = 0; bus.tiro_x = '0; bus.tiro_y = '0; bus.recarregar_vidas = 0;
    endtask

    function automatic int toward(input int c, input int t);
        return (c < t) ? c + 1 : (c > t) ? c - 1 : c;
    endfunction

    function automatic bit any_free();
        for (int i = 0; i < N; i++) if (!ma[i]) return 1;
        return 0;
    endfunction

    function automatic int pick_active_x_or(input int dflt, output int yy);
        int cand[$];
        for (int i = 0; i < N; i++) if (ma[i]) cand.push_back(i);
        if (cand.size() == 0) begin yy = $urandom_range(0, 15); return dflt; end
        begin
            int k = cand[$urandom_range(0, cand.size() - 1)];
            yy = my[k];
            return mx[k];
        end
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin ma[i] = 0; mx[i] = 0; my[i] = 0; end
        lives = VINI; score = 0;
    endtask

    task automatic model_scan(input bit rec);
        snap_t s;
        if (rec) lives = VINI;
        for (int i = 0; i < N; i++) begin
            if (ma[i]) begin
                mx[i] = toward(mx[i], NX);
                my[i] = toward(my[i], NY);
                if (mx[i] == NX && my[i] == NY) begin
                    ma[i] = 0;
                    if (!rec && lives > 0) lives--;
                    col_q.push_back(lives);
                end
            end
        end
        s.nat = 0; s.x = '0; s.y = '0;
        for (int i = 0; i < N; i++) begin
            s.act[i] = ma[i];
            s.x[i*W +: W] = W'(mx[i]);
            s.y[i*W +: W] = W'(my[i]);
            s.nat += ma[i] ? 1 : 0;
        end
        s.lives = lives; s.score = score;
        fim_q.push_back(s);
    endtask

    // One idle-state command cycle, followed by a full scan when ini is set
    task automatic op(input bit sv, input int sx, input int sy, input bit tv, input int tx,
                      input int ty, input bit ini, input bit rec);
        int hits, slot, ry;
        chk("spawn_ready", bus.spawn_ready, any_free());
        chk("ocupado_idle", bus.ocupado, 0);
        bus.spawn_valid = sv; bus.spawn_x = W'(sx); bus.spawn_y = W'(sy);
        bus.tiro_valid = tv; bus.tiro_x = W'(tx); bus.tiro_y = W'(ty);
        bus.iniciar_passo = ini; bus.recarregar_vidas = rec;
        hits = 0; slot = -1;
        if (sv) for (int i = N - 1; i >= 0; i--) if (!ma[i]) slot = i;
        if (tv) for (int i = 0; i < N; i++)
            if (ma[i] && mx[i] == tx && my[i] == ty) begin ma[i] = 0; hits++; end
        if (slot >= 0) begin ma[slot] = 1; mx[slot] = sx; my[slot] = sy; end
        if (hits > 0) begin
            score = (score + hits > PMAX) ? PMAX : score + hits;
            hit_q.push_back(score);
        end
        if (rec) lives = VINI;
        if (ini) model_scan(rec);
        tick();
        idle_inputs();
        if (ini) begin
            for (int k = 0; k <= N; k++) begin
                bus.recarregar_vidas = rec;
                bus.spawn_valid = 1'($urandom);
                bus.spawn_x = W'($urandom); bus.spawn_y = W'($urandom);
                bus.tiro_valid = 1'($urandom);
                bus.tiro_x = W'(pick_active_x_or(0, ry)); bus.tiro_y = W'(ry);
                tick();
            end
            idle_inputs();
        end
    endtask

    initial begin : monitor
        snap_t e;
        logic [N*W-1:0] mask;
        forever begin
            @(negedge clock);
            if (bus.colisao === 1'b1) begin
                chk("colisao_expected", col_q.size() != 0, 1);
                if (col_q.size() != 0) chk("vidas_at_colisao", bus.num_vidas, col_q.pop_front());
            end
            if (bus.acertou === 1'b1) begin
                chk("acertou_expected", hit_q.size() != 0, 1);
                if (hit_q.size() != 0) chk("pontos_at_acertou", bus.pontos, hit_q.pop_front());
            end
            if (bus.passo_fim === 1'b1) begin
                chk("passo_fim_expected", fim_q.size() != 0, 1);
                if (fim_q.size() != 0) begin
                    e = fim_q.pop_front();
                    mask = '0;
                    for (int i = 0; i < N; i++) if (e.act[i]) mask[i*W +: W] = '1;
                    chk("db_ativos", bus.db_ativos, e.act);
                    chk("num_ativos", bus.num_ativos, e.nat);
                    chk("db_coor_x", bus.db_coor_x & mask, e.x & mask);
                    chk("db_coor_y", bus.db_coor_y & mask, e.y & mask);
                    chk("num_vidas", bus.num_vidas, e.lives);
                    chk("vidas", bus.vidas, e.lives != 0);
                    chk("pontos", bus.pontos, e.score);
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int sx, sy, tx, ty;
        idle_inputs();
        model_reset();
        repeat (2) @(posedge clock);
        #1 clear_n = 1'b1;
        chk("rst_num_vidas", bus.num_vidas, VINI);
        chk("rst_pontos", bus.pontos, 0);
        chk("rst_db_ativos", bus.db_ativos, 0);
        chk("rst_ocupado", bus.ocupado, 0);
        chk("rst_passo_fim", bus.passo_fim, 0);
        chk("rst_spawn_ready", bus.spawn_ready, 1);

        // Reset while the scan is at slot 2: no passo_fim may follow
        bus.spawn_valid = 1; bus.spawn_x = 4'd9; bus.spawn_y = 4'd9;
        tick();
        idle_inputs(); bus.iniciar_passo = 1;
        tick();
        idle_inputs();
        tick(); tick();
        clear_n = 1'b0;
        #1;
        chk("midscan_ocupado", bus.ocupado, 0);
        chk("midscan_db_ativos", bus.db_ativos, 0);
        chk("midscan_num_ativos", bus.num_ativos, 0);
        chk("midscan_passo_fim", bus.passo_fim, 0);
        tick();
        clear_n = 1'b1;
        repeat (N + 3) tick();

        // Single asteroid step, then collision path
        op(1, 6, 3, 0, 0, 0, 0, 0);
        op(0, 0, 0, 0, 0, 0, 1, 0);
        chk("step_x", bus.db_coor_x[W-1:0], 5);
        chk("step_y", bus.db_coor_y[W-1:0], 2);
        chk("step_num_ativos", bus.num_ativos, 1);
        op(1, 5, 1, 0, 0, 0, 0, 0);
        op(0, 0, 0, 0, 0, 0, 1, 0);
        op(0, 0, 0, 0, 0, 0, 1, 0);

        // Fill every slot, overflow spawn, shoot slot 2
        for (int i = 0; i < N + 1; i++) op(1, 8 + i, 10 + i, 0, 0, 0, 0, 0);
        chk("full_spawn_ready", bus.spawn_ready, 0);
        op(0, 0, 0, 1, 10, 12, 0, 0);
        chk("after_hit_spawn_ready", bus.spawn_ready, 1);

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            sx = $urandom_range(0, 15); sy = $urandom_range(0, 15);
            if ($urandom_range(0, 9) == 0) begin sx = NX; sy = NY; end
            tx = pick_active_x_or($urandom_range(0, 15), ty);
            if ($urandom_range(0, 4) == 0) begin tx = sx; ty = sy; end
            op($urandom_range(0, 99) < 45, sx, sy, $urandom_range(0, 99) < 35, tx, ty,
               $urandom_range(0, 99) < 40, $urandom_range(0, 99) < 5);
        end

        // Clear the field, then drive score into saturation
        for (int i = 0; i < N; i++) if (ma[i]) op(0, 0, 0, 1, mx[i], my[i], 0, 0);
        for (int r = 0; r < 70; r++) begin
            for (int i = 0; i < N; i++) op(1, 1, 1, 0, 0, 0, 0, 0);
            op(0, 0, 0, 1, 1, 1, 0, 0);
        end
        chk("pontos_saturated", bus.pontos, PMAX);

        // Lives saturate at zero, then reload during a colliding scan
        for (int r = 0; r < 4; r++) begin
            op(1, NX, NY, 0, 0, 0, 0, 0);
            op(0, 0, 0, 0, 0, 0, 1, 0);
        end
        chk("vidas_zero", bus.num_vidas, 0);
        chk("vidas_flag_zero", bus.vidas, 0);
        op(1, NX, NY, 0, 0, 0, 0, 0);
        op(0, 0, 0, 0, 0, 0, 1, 1);
        chk("vidas_reloaded", bus.num_vidas, VINI);

        repeat (3) tick();
        chk("col_q_drained", col_q.size(), 0);
        chk("hit_q_drained", hit_q.size(), 0);
        chk("fim_q_drained", fim_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
